bg_tile_renderer: RTL

Read side of the background tile RAM. Every pixel clock it turns the VGA scan position (`x`, `y`) and the fine scroll offset `bg_x_offset` into a background-RAM read and decodes the returned tile entry. It then fetches the texel from the tile-sheet ROM and presents a registered RGB pixel with an opacity flag to the pixel mixer. The game engine fills the RAM on port A; this block owns port B (read-only) and issues a read every cycle.

---
 rtl/tile_pkg.sv | 23 ++
 rtl/tile_addr_gen.sv | 31 +++
 rtl/bg_tile_renderer.sv | 114 +++++++++++
 3 files changed

// File: rtl/tile_pkg.sv
// Shared tile-map definitions: sheet geometry and the background tile-entry layout.
// Also used by the engine-side writers that fill the background RAM.
package tile_pkg;

    localparam int TILE_W      = 16;
    localparam int TILE_H      = 16;
    localparam int SHEET_TILES = 8;

    localparam int TE_COL   = 0;
    localparam int TE_ROW   = 3;
    localparam int TE_XFLIP = 6;
    localparam int TE_YFLIP = 7;
    localparam int TE_EN    = 8;

    typedef struct packed {
        logic       en;
        logic       yflip;
        logic       xflip;
        logic [2:0] row;
        logic [2:0] col;
    } tile_entry_t;

endpackage

// File: rtl/tile_addr_gen.sv
// Combinational tile entry + in-tile coordinate -> tile-sheet texel address.
// Flip muxes exist only when BG_FLIP_EN is defined.
module tile_addr_gen
    import tile_pkg::*;
(
    input  tile_entry_t entry_i,
    input  logic [3:0]  px_i,
    input  logic [3:0]  py_i,
    output logic [13:0] rom_addr_o
);

    logic [3:0] px_f;
    logic [3:0] py_f;
    logic       unused_en;

    assign unused_en = entry_i.en;

`ifdef BG_FLIP_EN
    // 15 - v is the bitwise inverse for a 4-bit coordinate
    assign px_f = entry_i.xflip ? ~px_i : px_i;
    assign py_f = entry_i.yflip ? ~py_i : py_i;
`else
    logic unused_flip;
    assign unused_flip = entry_i.xflip ^ entry_i.yflip;
    assign px_f = px_i;
    assign py_f = py_i;
`endif

    assign rom_addr_o = {entry_i.row, py_f, entry_i.col, px_f};

endmodule

// File: rtl/bg_tile_renderer.sv
// Background tile renderer: scan position -> tile RAM read -> texel fetch -> RGB pixel, 5-cycle latency.
// Optional feature macro: BG_FLIP_EN (honour per-tile X/Y flip bits).
module bg_tile_renderer
    import tile_pkg::*;
#(
    parameter int          TILE_COLS = 40,
    parameter int          TILE_ROWS = 30,
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [3:0]  bg_x_offset,
    output logic [15:0] bg_ram_addr,
    input  logic [31:0] bg_ram_dout,
    output logic [13:0] tile_rom_addr,
    input  logic [11:0] tile_rom_data,
    output logic [11:0] pix_rgb,
    output logic        pix_opaque,
    output logic        pix_valid
);

    localparam logic [6:0] COLS_C  = 7'(TILE_COLS);
    localparam logic [9:0] Y_LIMIT = 10'(TILE_ROWS * TILE_H);

    logic [10:0] sx_d;
    logic [6:0]  tc_raw;
    logic [6:0]  tc_d;
    logic [15:0] addr_d;
    logic        blank_d;

    assign sx_d    = {1'b0, x} + {7'b0, bg_x_offset};
    assign tc_raw  = sx_d[10:4];
    assign tc_d    = (tc_raw >= COLS_C) ? tc_raw - COLS_C : tc_raw;
    assign addr_d  = {9'b0, tc_d} + 16'(y[9:4]) * 16'(TILE_COLS);
    assign blank_d = !video_on || (y >= Y_LIMIT);

    logic [15:0] bg_ram_addr_q;
    logic [3:0]  px_p1_q, py_p1_q, px_p2_q, py_p2_q;
    logic        blank_p1_q, blank_p2_q;
    logic        vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
    logic [13:0] tile_rom_addr_q;
    logic        draw_p3_q, draw_p4_q;
    logic [11:0] pix_rgb_q;
    logic        pix_opaque_q, pix_valid_q;

    tile_entry_t entry;
    logic [13:0] rom_addr_d;
    logic        unused_ram_bits;

    assign entry           = tile_entry_t'(bg_ram_dout[TE_EN:TE_COL]);
    assign unused_ram_bits = ^bg_ram_dout[31:TE_EN+1];

    tile_addr_gen u_addr_gen (
        .entry_i    (entry),
        .px_i       (px_p2_q),
        .py_i       (py_p2_q),
        .rom_addr_o (rom_addr_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            bg_ram_addr_q   <= '0;
            px_p1_q         <= '0;
            py_p1_q         <= '0;
            blank_p1_q      <= 1'b1;
            vld_p1_q        <= 1'b0;
            px_p2_q         <= '0;
            py_p2_q         <= '0;
            blank_p2_q      <= 1'b1;
            vld_p2_q        <= 1'b0;
            tile_rom_addr_q <= '0;
            draw_p3_q       <= 1'b0;
            vld_p3_q        <= 1'b0;
            draw_p4_q       <= 1'b0;
            vld_p4_q        <= 1'b0;
            pix_rgb_q       <= '0;
            pix_opaque_q    <= 1'b0;
            pix_valid_q     <= 1'b0;
        end else begin
            // E1: issue RAM read, capture in-tile coordinates
            bg_ram_addr_q   <= addr_d;
            px_p1_q         <= sx_d[3:0];
            py_p1_q         <= y[3:0];
            blank_p1_q      <= blank_d;
            vld_p1_q        <= video_on;
            // cycle 2: RAM access in flight
            px_p2_q         <= px_p1_q;
            py_p2_q         <= py_p1_q;
            blank_p2_q      <= blank_p1_q;
            vld_p2_q        <= vld_p1_q;
            // E3: decode entry, issue ROM read
            tile_rom_addr_q <= rom_addr_d;
            draw_p3_q       <= !blank_p2_q && entry.en;
            vld_p3_q        <= vld_p2_q;
            // cycle 4: ROM access in flight
            draw_p4_q       <= draw_p3_q;
            vld_p4_q        <= vld_p3_q;
            // E5: output select
            pix_rgb_q       <= draw_p4_q ? tile_rom_data : 12'h000;
            pix_opaque_q    <= draw_p4_q && (tile_rom_data != KEY_COLOR);
            pix_valid_q     <= vld_p4_q;
        end
    end

    assign bg_ram_addr   = bg_ram_addr_q;
    assign tile_rom_addr = tile_rom_addr_q;
    assign pix_rgb       = pix_rgb_q;
    assign pix_opaque    = pix_opaque_q;
    assign pix_valid     = pix_valid_q;

endmodule
